program_loader: RTL
===================

# program_loader

Boot-time program loader that sits directly upstream of the 8-bit CPU core. It accepts a framed byte stream from a host link and writes the payload into the CPU's 16-byte unified instruction/data memory through a write port. It holds the CPU in reset while loading and releases it only after a verified checksum. A later valid header re-holds the CPU and reloads it.

## Interface
- `MEM_DEPTH`, 16: memory words. Must be a power of two, at most 256.
- `ADDR_W`, 4: memory address width, $clog2(MEM_DEPTH).
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT`, 255: idle cycles allowed mid-frame before abort. Range 1..65535.
- `clk`  in  1  system clock. Single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  loader can accept a byte. A byte transfers when `in_valid && in_ready`.
- `mem_we`  out  1  memory write strobe, one cycle per payload byte.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  8  write data.
- `cpu_hold`  out  1  active-high reset to the CPU core.
- `loaded`  out  1  a verified program is resident and the CPU is running.
- `err_csum`  out  1  sticky error: checksum mismatch.
- `err_len`  out  1  sticky error: length field is 0 or greater than MEM_DEPTH.
- `err_timeout`  out  1  sticky error: frame stalled.

## Operation
- Frame format:
  - byte 0: HEADER;
  - byte 1: payload length N, 1..MEM_DEPTH;
  - bytes 2..N+1: payload, written to addresses 0..N-1 in order;
  - final byte: checksum, the 8-bit modulo-256 sum of the payload bytes.
- States:
  - IDLE: non-HEADER bytes are dropped. HEADER goes to LEN and clears all `err_*`.
  - LEN: N is 0 or greater than MEM_DEPTH → set `err_len` and go to IDLE. Otherwise latch N, clear the address counter and running sum, and go to DATA.
  - DATA: each accepted byte is written, then the address increments and the sum accumulates. After the Nth byte, go to CSUM.
  - CSUM: byte equals sum → RUN. Mismatch → set `err_csum` and go to IDLE.
  - RUN: `cpu_hold`=0 and `loaded`=1. A HEADER byte sets `cpu_hold`=1 and `loaded`=0 in the next cycle, clears `err_*` and goes to LEN. Other bytes are dropped.
- `cpu_hold` is 1 in every state except RUN. An aborted frame never releases the CPU. Memory contents written before an abort are left as-is.
- `in_ready` is 1 in every state. No back-pressure; the loader absorbs one byte per cycle.
- Timeout:
  - A counter runs in LEN, DATA and CSUM only, reloading on each accepted byte.
  - Reaching TIMEOUT idle cycles sets `err_timeout` and forces IDLE.
- Arithmetic: the sum is an 8-bit wrapping register. The address counter is ADDR_W bits and cannot wrap within a legal frame, since N ≤ MEM_DEPTH.

## Timing
- Reset (`reset_n`=0, asynchronous) puts the block in this state:
  - IDLE; `cpu_hold`=1, `in_ready`=1;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `loaded`=0 and all `err_*`=0;
  - counters and sum at 0.
- Reset asserted mid-frame aborts immediately. The CPU stays held.
- Write latency: a payload byte accepted at edge t appears with `mem_we`=1 and its address/data during cycle t→t+1. Outputs are registered.
- Release latency: a checksum byte accepted at edge t gives `cpu_hold`=0 and `loaded`=1 from t onward. The CPU therefore leaves reset one cycle after the last memory write.
- Errors assert in the cycle following the offending byte or the timeout expiry, and stay set until the next HEADER or reset.
- A HEADER byte inside a payload (DATA) is data, not a restart.

## Structure
- Shared package `cpu_pkg` holds:
  - the `loader_state_t` enum (IDLE, LEN, DATA, CSUM, RUN);
  - the HEADER default;
  - the memory word width (8) and default depth (16), shared with the CPU core.
- One sub-module, `idle_timer`: loadable down-counter with `expired` output, parameterised by TIMEOUT.

## Test plan
- Good frame A5 05 13 94 20 6A 74 A5 → memory[0..4]=13,94,20,6A,74; exactly 5 `mem_we` pulses; `cpu_hold` falls one cycle after the last write; `loaded`=1; no errors.
- Same frame with checksum A4 → `err_csum`=1, `cpu_hold` stays 1, state IDLE; the following good frame loads and clears `err_csum`.
- Length byte 00, and separately 11 (hex) → `err_len`=1, no `mem_we` pulses.
- Frame stalls after the 2nd payload byte for TIMEOUT cycles (TIMEOUT=8 in the bench) → `err_timeout`=1, 2 writes done, CPU held. A byte arriving at cycle 7 of the stall resets the counter and produces no error.
- While in RUN, send A5 01 FF FF → `cpu_hold` goes back to 1 on the header, memory[0]=FF, re-released. Payload byte A5 inside DATA is written as data.
- `reset_n` pulsed low mid-DATA → all outputs at reset values immediately; `cpu_hold`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU core and its boot-time program loader.
package cpu_pkg;

    // Memory word width and default depth of the unified instruction/data memory.
    localparam int WORD_W            = 8;
    localparam int MEM_DEPTH_DEFAULT = 16;

    // Byte that opens every loader frame.
    localparam logic [WORD_W-1:0] HEADER_DEFAULT = 8'hA5;

    // Loader frame-parser states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/program_loader_idle_timer.sv
// Loadable down-counter that flags when a frame has stalled for TIMEOUT cycles.
module idle_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Reload on every accepted byte, otherwise count down while a frame is open.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 16'(TIMEOUT);
        end else if (count_i && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // At a count of one, the next idle cycle is the TIMEOUT-th one.
    assign expired_o = (cnt_q == 16'd1);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses framed host bytes, writes payload to CPU memory and
// releases the CPU from reset only after a verified checksum.
module program_loader
    import cpu_pkg::*;
#(
    parameter int                MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int                ADDR_W    = $clog2(MEM_DEPTH),
    parameter logic [WORD_W-1:0] HEADER    = HEADER_DEFAULT,
    parameter int                TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              loaded,
    output logic              err_csum,
    output logic              err_len,
    output logic              err_timeout
);

    localparam logic [8:0] MAX_LEN = 9'(MEM_DEPTH);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        remain_q, remain_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, loaded_q;
    logic              err_csum_q, err_csum_d;
    logic              err_len_q, err_len_d;
    logic              err_timeout_q, err_timeout_d;

    logic accept;
    logic timed;
    logic expired;
    logic timeout_hit;

    // No back-pressure: every offered byte is taken.
    assign accept = in_valid;
    assign timed  = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (accept),
        .count_i   (timed),
        .expired_o (expired)
    );

    assign timeout_hit = timed && !accept && expired;

    // Frame parser: next state, memory write request, counters and sticky errors.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        sum_d         = sum_q;
        remain_d      = remain_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        err_csum_d    = err_csum_q;
        err_len_d     = err_len_q;
        err_timeout_d = err_timeout_q;
        if (timeout_hit) begin
            err_timeout_d = 1'b1;
            state_d       = IDLE;
        end else if (accept) begin
            case (state_q)
                IDLE, RUN: begin
                    if (in_data == HEADER) begin
                        state_d       = LEN;
                        err_csum_d    = 1'b0;
                        err_len_d     = 1'b0;
                        err_timeout_d = 1'b0;
                    end
                end
                LEN: begin
                    if ((in_data == '0) || ({1'b0, in_data} > MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        remain_d = in_data;
                        addr_d   = '0;
                        sum_d    = 8'd0;
                        state_d  = DATA;
                    end
                end
                DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + 1'b1;
                    sum_d       = sum_q + in_data;
                    remain_d    = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = CSUM;
                    end
                end
                CSUM: begin
                    if (in_data == sum_q) begin
                        state_d = RUN;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters and registered outputs; CPU held except in RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            sum_q         <= 8'd0;
            remain_q      <= 8'd0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_hold_q    <= 1'b1;
            loaded_q      <= 1'b0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            sum_q         <= sum_d;
            remain_q      <= remain_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_hold_q    <= (state_d != RUN);
            loaded_q      <= (state_d == RUN);
            err_csum_q    <= err_csum_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign in_ready    = 1'b1;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_hold    = cpu_hold_q;
    assign loaded      = loaded_q;
    assign err_csum    = err_csum_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;

endmodule
